// File: rtl/seg7_scan_ctrl.sv
// Purpose : round-robin scan of NUM_DIGITS common-cathode digits over one shared seg7 bus.
// Latency : digit_sel/code_out/frame_tick registered (1 clk); an accepted write is stored at the next edge.
// Backpres: wr_ready drops only while the addressed digit is being driven; every other write is accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               1 = scan runs, 0 = scan frozen and display dark
//   wr_valid/wr_ready write handshake; wr_addr selects the digit, wr_data is the nibble
//   code_out          nibble of the digit currently driven (to the seg7 decoder)
//   digit_sel         one-hot active-high digit enable
//   frame_tick        one-cycle pulse on the last drive cycle of the top digit
//
// Optional feature: define SEG7_SCAN_LZB_EN for leading-zero blanking (digits above
// the most significant non-zero digit stay dark; digit 0 is always driven).

module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 4,
    parameter int BLANK_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    output logic [3:0]            code_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_tick
);

    localparam int CW   = $clog2(NUM_DIGITS);
    localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int TW   = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] CUR_LAST   = CW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cur, cur_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [3:0]      digits [NUM_DIGITS];

    logic [3:0]      eff [NUM_DIGITS];
    logic [2:0]      cur_ext;
    logic            wr_fire;
    logic            slot_start;
    logic            drive_nxt;
    logic [3:0]      code_nxt;
    logic [NUM_DIGITS-1:0] sel_nxt;
    logic            tick_nxt;

    assign cur_ext = 3'(cur);

    // Only the digit on the bus right now is protected; a frozen scan shows
    // nothing, so every write is safe then.
    assign wr_ready = !(ena && (state == ST_DRIVE) && (wr_addr == cur_ext));
    assign wr_fire  = wr_valid && wr_ready;

    // Digit contents as they will be after this edge's write. Sampling this at
    // slot start lets a write landing in the last blank cycle show for the
    // whole slot instead of one slot late.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            eff[i] = (wr_fire && (wr_addr == 3'(i))) ? wr_data : digits[i];
        end
    end

    // Scan sequencer: blank gap, then DWELL drive cycles, then next digit.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        timer_nxt = timer;
        if (ena) begin
            case (state)
                ST_BLANK: begin
                    if (timer == BLANK_LAST) begin
                        state_nxt = ST_DRIVE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (timer == DWELL_LAST) begin
                        state_nxt = ST_BLANK;
                        timer_nxt = '0;
                        cur_nxt   = (cur == CUR_LAST) ? '0 : cur + CW'(1);
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    assign slot_start = ena && (state == ST_BLANK) && (state_nxt == ST_DRIVE);
    assign drive_nxt  = ena && (state_nxt == ST_DRIVE);
    assign code_nxt   = slot_start ? eff[cur] : code_out;
    // cur does not change on the blank->drive step, so cur names the slot digit.
    assign tick_nxt   = drive_nxt && (timer_nxt == DWELL_LAST) && (cur == CUR_LAST);

`ifdef SEG7_SCAN_LZB_EN
    logic lead_zero;
    logic dark_q, dark_nxt;

    // Dark if this digit and every higher one is zero; digit 0 never blanks.
    always_comb begin
        lead_zero = (cur != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(cur)) && (eff[i] != 4'd0)) begin
                lead_zero = 1'b0;
            end
        end
    end

    // Decision is latched at slot start so a mid-slot write to a higher digit
    // cannot flicker the current digit.
    assign dark_nxt = slot_start ? lead_zero : dark_q;
    assign sel_nxt  = (drive_nxt && !dark_nxt) ? (NUM_DIGITS'(1) << cur) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dark_q <= 1'b0;
        end else begin
            dark_q <= dark_nxt;
        end
    end
`else
    assign sel_nxt = drive_nxt ? (NUM_DIGITS'(1) << cur) : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cur        <= '0;
            timer      <= '0;
            code_out   <= '0;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur        <= cur_nxt;
            timer      <= timer_nxt;
            code_out   <= code_nxt;
            digit_sel  <= sel_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Addresses beyond the last digit match no register and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_fire && (wr_addr == 3'(i))) begin
                    digits[i] <= wr_data;
                end
            end
        end
    end

endmodule
